// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: D-stage stall / forwarding controller with a private
// scoreboard of the NPROD downstream stages (entry 0 = E, 1 = M, 2 = W ...)
// and a multiply/divide busy countdown.

`ifndef TUSE_IGNORE
`define TUSE_IGNORE (-1)
`endif

module hazard_scoreboard #(
  parameter int T_SIZE     = 3,
  parameter int NPROD      = 3,
  parameter int FS         = 3,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [4:0]             D_rs,
  input  logic [4:0]             D_rt,
  input  logic [T_SIZE-1:0]      D_Tuse_rs,
  input  logic [T_SIZE-1:0]      D_Tuse_rt,
  input  logic [4:0]             D_REG_write_number,
  input  logic                   D_REG_write_enable,
  input  logic [T_SIZE-1:0]      D_Tnew,
  input  logic                   D_MDU_request,
  input  logic                   D_MDU_start,
  input  logic                   D_MDU_div,
  output logic                   stall,
  output logic [NPROD*FS-1:0]    FWD_rs,
  output logic [NPROD*FS-1:0]    FWD_rt,
  output logic                   mdu_busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [T_SIZE-1:0] TUSE_IGN = T_SIZE'(`TUSE_IGNORE);

  // Producer side of an entry: needed in every stage.
  typedef struct packed {
    logic              valid;
    logic              we;
    logic [4:0]        wn;
    logic [T_SIZE-1:0] tnew;
  } prod_t;

  // Consumer side: the last stage never consumes a forward, so it is not kept.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
  } cons_t;

  prod_t [NPROD-1:0] prod;
  cons_t [NPROD-2:0] cons;
  logic              start0;   // entry 0 holds an MDU start
  logic [CW-1:0]     mdu_cnt;

  logic              use_d_rs, use_d_rt, issue;
  logic [NPROD-1:0]        live, ready;
  logic [NPROD-1:0][4:0]   wn_vec;
  logic [NPROD-1:0][FS-1:0] fwd_rs, fwd_rt;

  // Tnew counts down toward 0 and never goes negative.
  function automatic logic [T_SIZE-1:0] sat_dec(input logic [T_SIZE-1:0] t);
    return (t[T_SIZE-1] || t == '0) ? '0 : t - T_SIZE'(1);
  endfunction

  // Youngest matching producer at or older than slice s decides; a match that
  // is not ready yet masks anything older.
  function automatic logic [FS-1:0] fwd_sel(
    input logic [4:0]            src,
    input logic                  use_src,
    input int                    s,
    input logic [NPROD-1:0]      lv,
    input logic [NPROD-1:0][4:0] wn,
    input logic [NPROD-1:0]      rdy
  );
    logic [FS-1:0] sel;
    sel = '0;
    for (int j = NPROD - 1; j >= 0; j--) begin
      if (j >= s && use_src && lv[j] && wn[j] == src)
        sel = rdy[j] ? FS'(j + 1) : '0;
    end
    return sel;
  endfunction

  assign use_d_rs = (D_Tuse_rs != TUSE_IGN);
  assign use_d_rt = (D_Tuse_rt != TUSE_IGN);
  assign mdu_busy = (mdu_cnt != '0);
  assign issue    = !stall && !flush;

  // Per-entry producer summary: a live GPR writer and whether its value exists.
  always_comb begin
    for (int j = 0; j < NPROD; j++) begin
      live[j]   = prod[j].valid && prod[j].we && prod[j].wn != 5'd0;
      wn_vec[j] = prod[j].wn;
      ready[j]  = (prod[j].tnew == '0);
    end
  end

  // Stall when a D operand's producer cannot deliver in time, or HI/LO is busy.
  always_comb begin
    stall = D_MDU_request && mdu_busy;
    for (int j = 0; j < NPROD; j++) begin
      if (live[j] && use_d_rs && wn_vec[j] == D_rs &&
          $signed(prod[j].tnew) > $signed(D_Tuse_rs))
        stall = 1'b1;
      if (live[j] && use_d_rt && wn_vec[j] == D_rt &&
          $signed(prod[j].tnew) > $signed(D_Tuse_rt))
        stall = 1'b1;
    end
  end

  // One forwarding select per consumer slice: slice 0 is D, slice k+1 is entry k.
  for (genvar s = 0; s < NPROD; s++) begin : g_slice
    logic [4:0] c_rs, c_rt;
    logic       c_use_rs, c_use_rt;
    if (s == 0) begin : g_d
      assign c_rs     = D_rs;
      assign c_rt     = D_rt;
      assign c_use_rs = use_d_rs;
      assign c_use_rt = use_d_rt;
    end else begin : g_e
      assign c_rs     = cons[s-1].rs;
      assign c_rt     = cons[s-1].rt;
      assign c_use_rs = cons[s-1].use_rs;
      assign c_use_rt = cons[s-1].use_rt;
    end
    assign fwd_rs[s] = fwd_sel(c_rs, c_use_rs, s, live, wn_vec, ready);
    assign fwd_rt[s] = fwd_sel(c_rt, c_use_rt, s, live, wn_vec, ready);
  end

  assign FWD_rs = fwd_rs;
  assign FWD_rt = fwd_rt;

  // Scoreboard shift: age every entry, load D or a bubble into entry 0.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      prod   <= '0;
      cons   <= '0;
      start0 <= 1'b0;
    end else begin
      for (int k = NPROD - 1; k > 0; k--) begin
        prod[k].valid <= prod[k-1].valid;
        prod[k].we    <= prod[k-1].we;
        prod[k].wn    <= prod[k-1].wn;
        prod[k].tnew  <= sat_dec(prod[k-1].tnew);
      end
      for (int k = NPROD - 2; k > 0; k--)
        cons[k] <= cons[k-1];
      if (stall) begin
        prod[0] <= '0;
        cons[0] <= '0;
        start0  <= 1'b0;
      end else begin
        prod[0].valid  <= 1'b1;
        prod[0].we     <= D_REG_write_enable;
        prod[0].wn     <= D_REG_write_number;
        prod[0].tnew   <= D_Tnew;
        cons[0].rs     <= D_rs;
        cons[0].rt     <= D_rt;
        cons[0].use_rs <= use_d_rs;
        cons[0].use_rt <= use_d_rt;
        start0         <= D_MDU_start;
      end
    end
  end

  // MDU busy countdown; a start squashed while still in E cancels it.
  always_ff @(posedge clk) begin
    if (reset)
      mdu_cnt <= '0;
    else if (flush && start0)
      mdu_cnt <= '0;
    else if (issue && D_MDU_start)
      mdu_cnt <= D_MDU_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
    else if (mdu_cnt != '0)
      mdu_cnt <= mdu_cnt - CW'(1);
  end

endmodule
